// File: rtl/regfile_ctrl.sv
// Round-robin sequencer for two requesters onto a 1R/1W register file.
// Latency: WRITE 1, READ/MOV 2, ADD 3 cycles from acceptance; no response back-pressure.
module regfile_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [3:0]      req_op,
  input  logic [2*AW-1:0] req_rd,
  input  logic [2*AW-1:0] req_ra,
  input  logic [2*AW-1:0] req_rb,
  input  logic [2*DW-1:0] req_data,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [AW-1:0]   rf_raddr,
  input  logic [DW-1:0]   rf_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, EXEC} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_MOV, OP_ADD} op_t;

  state_t        state;
  op_t           op;
  logic [AW-1:0] rd, ra, rb;
  logic [DW-1:0] data, opa;
  logic          id;
  logic          last;

  logic          gnt_any, gnt;
  logic [1:0]    sel_op;
  logic [AW-1:0] sel_rd, sel_ra, sel_rb;
  logic [DW-1:0] sel_data;
  logic [DW-1:0] result;
  logic          exec_on;

  // Both valid: the requester not granted last wins; last resets to 1 so requester 0 starts ahead.
  always_comb begin
    gnt_any  = |req_valid;
    gnt      = (req_valid == 2'b11) ? ~last : req_valid[1];
    sel_op   = gnt ? req_op[3:2]           : req_op[1:0];
    sel_rd   = gnt ? req_rd[2*AW-1:AW]     : req_rd[AW-1:0];
    sel_ra   = gnt ? req_ra[2*AW-1:AW]     : req_ra[AW-1:0];
    sel_rb   = gnt ? req_rb[2*AW-1:AW]     : req_rb[AW-1:0];
    sel_data = gnt ? req_data[2*DW-1:DW]   : req_data[DW-1:0];
  end

  assign req_ready = (state == IDLE && gnt_any && !reset) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    case (op)
      OP_WRITE: result = data;
      OP_ADD:   result = opa + rf_rdata;
      default:  result = rf_rdata;
    endcase
  end

  // Outputs are masked while reset is high so an abandoned operation never writes or responds.
  assign exec_on   = (state == EXEC) && !reset;
  assign rf_we     = exec_on && (op != OP_READ);
  assign rf_waddr  = rf_we ? rd : '0;
  assign rf_wdata  = rf_we ? result : '0;
  assign rsp_valid = exec_on;
  assign rsp_id    = exec_on && id;
  assign rsp_data  = exec_on ? result : '0;
  assign rf_raddr  = (state == RD_A) ? ra : (state == RD_B) ? rb : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      op    <= OP_WRITE;
      rd    <= '0;
      ra    <= '0;
      rb    <= '0;
      data  <= '0;
      opa   <= '0;
      id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op    <= op_t'(sel_op);
            rd    <= sel_rd;
            ra    <= sel_ra;
            rb    <= sel_rb;
            data  <= sel_data;
            id    <= gnt;
            last  <= gnt;
            state <= (op_t'(sel_op) == OP_WRITE) ? EXEC : RD_A;
          end
        end
        RD_A: state <= (op == OP_ADD) ? RD_B : EXEC;
        RD_B: begin
          opa   <= rf_rdata;
          state <= EXEC;
        end
        EXEC: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Sequencing controller for the 4 x 8-bit register file. It accepts register operations from two requesters, arbitrates round-robin, and runs each operation as a short multi-cycle sequence on the file's single read port and single write port. Supported operations are write-immediate, read, move and add. It sits between the switch/key front end (or any future datapath client) and the register file, so the file itself stays a plain storage array.

## Interface
Parameters:
- DW, 8, data width of each register
- AW, 2, register address width (2**AW registers)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i's operation is accepted this cycle (one-cycle pulse)
- req_op  in  4  [2i+1:2i] opcode of requester i: 00 WRITE, 01 READ, 10 MOV, 11 ADD
- req_rd  in  2*AW  destination register, per requester
- req_ra  in  2*AW  source A register, per requester
- req_rb  in  2*AW  source B register, per requester (ADD only)
- req_data  in  2*DW  immediate value, per requester (WRITE only)
- rsp_valid  out  1  one-cycle pulse: operation complete
- rsp_id  out  1  requester that issued the completed operation
- rsp_data  out  DW  value written (WRITE/MOV/ADD) or read (READ)
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- rf_raddr  out  AW  register file read address
- rf_rdata  in  DW  read data for the rf_raddr presented in the previous cycle (registered read)
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, RD_A, RD_B, EXEC.
- IDLE: if any req_valid is set, grant one requester. A single valid requester is granted directly. If both are valid, grant the requester not granted last; after reset, requester 0 has priority.
  - req_ready[g] is combinational: high only in IDLE for the granted requester.
  - On acceptance, latch op, rd, ra, rb, data and id.
  - Next state: WRITE goes to EXEC; READ, MOV and ADD go to RD_A.
- RD_A: rf_raddr = ra. Next state: ADD goes to RD_B; otherwise EXEC.
- RD_B: capture rf_rdata into operand A; rf_raddr = rb; next state EXEC.
- EXEC: compute the result.
  - WRITE: result = data.
  - READ and MOV: result = rf_rdata.
  - ADD: result = operand A + rf_rdata, truncated to DW bits (mod 2**DW, no carry out).
  - rf_we = 1 for WRITE, MOV and ADD, with rf_waddr = rd and rf_wdata = result. READ never writes.
  - rsp_valid = 1, rsp_id = latched id, rsp_data = result, for every op.
  - Next state: IDLE.
- rsp has no back-pressure.
- Request fields must be held stable while req_valid is high. They are not sampled after acceptance.
- ra == rb and rd == ra are legal: operands are read before the write in EXEC.
- Outside RD_A/RD_B, rf_raddr = 0. Outside EXEC, rf_we, rf_waddr, rf_wdata, rsp_valid, rsp_id and rsp_data are all 0.

## Timing
- Reset values: state IDLE, last-grant pointer set so requester 0 wins, req_ready = 0, every registered output 0, busy = 0.
- Acceptance at cycle T. EXEC (write and response) occurs at:
  - WRITE: T+1
  - READ and MOV: T+2
  - ADD: T+3
- The earliest next acceptance is the cycle after EXEC. Issue intervals are therefore 2, 3 or 4 cycles.
- A write in EXEC at cycle E is visible to a read issued in RD_A at E+2 or later. Operations are fully serialized, so no hazards arise.
- Reset mid-operation: the operation is abandoned. No rf_we and no rsp_valid are produced. The state returns to IDLE and priority returns to requester 0. The requester already counts the operation as accepted; it is lost.
- A requester whose req_valid drops before it is granted is not served.

## Test plan
- Reset, then req0 issues WRITE rd=2 data=0x5A at T -> req_ready=01 at T; at T+1: rf_we=1, rf_waddr=2, rf_wdata=0x5A, rsp_valid=1, rsp_id=0, rsp_data=0x5A.
- With R2=0x5A in the file model, req1 issues READ ra=2 -> at T+1 rf_raddr=2; at T+2 rsp_data=0x5A, rsp_id=1, rf_we=0.
- R1=0xF0, R2=0x25; ADD rd=3 ra=1 rb=2 -> at T+3 rf_waddr=3, rf_wdata=0x15 (wrap); R3 reads back 0x15.
- Both requesters hold WRITE requests continuously from reset -> grants alternate 0,1,0,1, with acceptances spaced 2 cycles apart.
- Reset asserted during RD_B of an ADD -> no rf_we, no rsp_valid, busy=0 next cycle; with both requesters valid, next grant goes to requester 0.
- R1=0x40; ADD rd=1 ra=1 rb=1 -> R1=0x80. Then MOV rd=0 ra=1 -> R0=0x80, rsp_data=0x80 at T+2.
